uxa_ps2_busctl: RTL and testbench
=================================

# uxa_ps2_busctl

Wishbone slave control block for the UXA PS/2 port. It acknowledges every strobed bus cycle in the same cycle and, on writes, latches the two PS/2 line-drive enables (clock and data) from data bits 8 and 9. It also issues a one-cycle read-pointer increment to the receive FIFO after each write, so a write both sets the line state and pops the FIFO head. It sits between the Wishbone register decode and the PS/2 open-collector pad drivers/receive FIFO in the ps2io subsystem.

## Interface

Parameters: none.

Ports:
- sys_clk_i  input  1  system clock; all state changes on its rising edge.
- sys_reset_i  input  1  reset, asynchronous, active-low.
- wb_we_i  input  1  Wishbone write enable (1 = write, 0 = read).
- wb_stb_i  input  1  Wishbone strobe; a cycle is active while high.
- wb_dat_8_i  input  1  write data bit 8, the PS/2 clock line level request (0 = pull low, 1 = release).
- wb_dat_9_i  input  1  write data bit 9, the PS/2 data line level request (0 = pull low, 1 = release).
- wb_ack_o  output  1  Wishbone acknowledge, combinational.
- rp_inc_o  output  1  receive-FIFO read-pointer increment, registered, one cycle per write.
- c_oe_o  output  1  PS/2 clock pad driver enable (1 = drive line low), registered.
- d_oe_o  output  1  PS/2 data pad driver enable (1 = drive line low), registered.

## Operation

- Reset (sys_reset_i = 0, asynchronous): c_oe_o = 0, d_oe_o = 0, rp_inc_o = 0. Both lines are released and no pop is pending. wb_ack_o follows the rule below.
- Acknowledge: wb_ack_o = wb_stb_i, purely combinational, for reads and writes alike. There are no wait states. Each clock edge with wb_stb_i = 1 completes one transfer.
- Write (wb_stb_i = 1 and wb_we_i = 1 at a rising edge):
  - c_oe_o is loaded with ~wb_dat_8_i.
  - d_oe_o is loaded with ~wb_dat_9_i.
  - rp_inc_o is set to 1.
- Any other edge (read, or idle):
  - c_oe_o and d_oe_o hold their values.
  - rp_inc_o is cleared to 0.
- Equivalently: rp_inc_o is a register updated each edge from (wb_stb_i & wb_we_i).
- Reads never change c_oe_o or d_oe_o and never assert rp_inc_o. Read data is supplied by other logic.
- No state machine. The only state is three flip-flops: c_oe, d_oe, rp_inc.
- Reset asserted mid-cycle forces all three registers to 0 immediately. wb_ack_o still tracks wb_stb_i.

## Timing

- wb_ack_o rises in the same cycle wb_stb_i rises (zero-latency, combinational path).
- Write accepted at edge N:
  - c_oe_o and d_oe_o take their new values just after edge N.
  - rp_inc_o is high from just after edge N to just after edge N+1 (exactly one clock).
- rp_inc_o is low while the write cycle is being presented, before the accepting edge.
- Back-to-back writes (strobe held high with we = 1 across edges N and N+1): rp_inc_o stays high for two consecutive cycles, giving exactly two pops. It drops after the first edge at which strobe or we is low.
- Changing wb_we_i or the data bits between edges has no effect. Only values sampled at the rising edge matter.

## Test plan

- Reset: pulse sys_reset_i low with stb = 0, then release. Check c_oe_o = d_oe_o = rp_inc_o = wb_ack_o = 0.
- Single read: stb = 1, we = 0 for one cycle. Check wb_ack_o = 1 within the cycle, rp_inc_o = 0 throughout and on the following cycle, and the oe outputs unchanged.
- Single write, dat8 = 0, dat9 = 0:
  - wb_ack_o = 1 in the same cycle, rp_inc_o = 0 before the edge.
  - After the edge: c_oe_o = 1, d_oe_o = 1, and rp_inc_o = 1 for exactly one cycle.
- Write with dat8 = 1, dat9 = 1, then dat8 = 0, dat9 = 1: check oe outputs become (0,0), then (1,0). Each write gives one rp_inc_o pulse.
- Back-to-back writes: stb = we = 1 for two edges, then 0. Check rp_inc_o = 1 for exactly two consecutive cycles, then 0.
- Asynchronous reset mid-write: assert sys_reset_i low between edges while rp_inc_o = 1 and c_oe_o = 1. Check both clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/uxa_ps2_busctl.sv
// uxa_ps2_busctl
//   Wishbone slave control for the UXA PS/2 port. Every strobed cycle is
//   acknowledged combinationally (no wait states). A write latches the two
//   open-collector pad driver enables from data bits 8/9 (inverted: a 0
//   request pulls the line low) and produces a one-clock read-pointer
//   increment to the receive FIFO, so each write also pops the FIFO head.
//
// Ports
//   sys_clk_i    in   system clock, rising edge
//   sys_reset_i  in   asynchronous reset, active low
//   wb_we_i      in   Wishbone write enable
//   wb_stb_i     in   Wishbone strobe
//   wb_dat_8_i   in   requested PS/2 clock line level (0 = pull low)
//   wb_dat_9_i   in   requested PS/2 data line level (0 = pull low)
//   wb_ack_o     out  Wishbone acknowledge, combinational copy of strobe
//   rp_inc_o     out  receive-FIFO read-pointer increment, registered
//   c_oe_o       out  PS/2 clock pad driver enable (1 = drive low), registered
//   d_oe_o       out  PS/2 data pad driver enable (1 = drive low), registered
module uxa_ps2_busctl (
    input  logic sys_clk_i,
    input  logic sys_reset_i,
    input  logic wb_we_i,
    input  logic wb_stb_i,
    input  logic wb_dat_8_i,
    input  logic wb_dat_9_i,
    output logic wb_ack_o,
    output logic rp_inc_o,
    output logic c_oe_o,
    output logic d_oe_o
);

    logic wr_en;
    logic c_oe;
    logic d_oe;
    logic rp_inc;

    assign wr_en    = wb_stb_i & wb_we_i;
    assign wb_ack_o = wb_stb_i;

    always_ff @(posedge sys_clk_i or negedge sys_reset_i) begin
        if (!sys_reset_i) begin
            c_oe   <= 1'b0;
            d_oe   <= 1'b0;
            rp_inc <= 1'b0;
        end else begin
            // One pop per accepted write; back-to-back writes keep it high.
            rp_inc <= wr_en;
            if (wr_en) begin
                // Enables are active-high "drive low", so invert the level request.
                c_oe <= ~wb_dat_8_i;
                d_oe <= ~wb_dat_9_i;
            end
        end
    end

    assign rp_inc_o = rp_inc;
    assign c_oe_o   = c_oe;
    assign d_oe_o   = d_oe;

endmodule

// File: tb/tb_uxa_ps2_busctl.sv
module tb_uxa_ps2_busctl;

    logic sys_clk_i   = 1'b0;
    logic sys_reset_i = 1'b0;
    logic wb_we_i     = 1'b0;
    logic wb_stb_i    = 1'b0;
    logic wb_dat_8_i  = 1'b0;
    logic wb_dat_9_i  = 1'b0;
    logic wb_ack_o;
    logic rp_inc_o;
    logic c_oe_o;
    logic d_oe_o;

    int checks   = 0;
    int failures = 0;

    uxa_ps2_busctl dut (
        .sys_clk_i   (sys_clk_i),
        .sys_reset_i (sys_reset_i),
        .wb_we_i     (wb_we_i),
        .wb_stb_i    (wb_stb_i),
        .wb_dat_8_i  (wb_dat_8_i),
        .wb_dat_9_i  (wb_dat_9_i),
        .wb_ack_o    (wb_ack_o),
        .rp_inc_o    (rp_inc_o),
        .c_oe_o      (c_oe_o),
        .d_oe_o      (d_oe_o)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge sys_clk_i);
        #1;
    endtask

    // Single write cycle: present for one edge, then idle one edge.
    task automatic do_write(input string tag, input logic d8, input logic d9,
                            input logic exp_c, input logic exp_d);
        wb_stb_i   = 1'b1;
        wb_we_i    = 1'b1;
        wb_dat_8_i = d8;
        wb_dat_9_i = d9;
        #1;
        chk({tag, "_ack"}, wb_ack_o, 1'b1);
        chk({tag, "_rp_pre"}, rp_inc_o, 1'b0);
        step();
        chk({tag, "_c_oe"}, c_oe_o, exp_c);
        chk({tag, "_d_oe"}, d_oe_o, exp_d);
        chk({tag, "_rp_post"}, rp_inc_o, 1'b1);
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        step();
        chk({tag, "_rp_drop"}, rp_inc_o, 1'b0);
        chk({tag, "_c_hold"}, c_oe_o, exp_c);
        chk({tag, "_d_hold"}, d_oe_o, exp_d);
    endtask

    initial begin
        // Reset asserted from time 0, strobe low.
        #12;
        chk("rst_c_oe", c_oe_o, 1'b0);
        chk("rst_d_oe", d_oe_o, 1'b0);
        chk("rst_rp", rp_inc_o, 1'b0);
        chk("rst_ack", wb_ack_o, 1'b0);
        sys_reset_i = 1'b1;
        step();
        chk("post_rst_c_oe", c_oe_o, 1'b0);
        chk("post_rst_rp", rp_inc_o, 1'b0);

        // Single read.
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b0;
        wb_dat_8_i = 1'b0;
        wb_dat_9_i = 1'b0;
        #1;
        chk("rd_ack", wb_ack_o, 1'b1);
        chk("rd_rp_pre", rp_inc_o, 1'b0);
        step();
        chk("rd_rp_post", rp_inc_o, 1'b0);
        chk("rd_c_oe", c_oe_o, 1'b0);
        chk("rd_d_oe", d_oe_o, 1'b0);
        wb_stb_i = 1'b0;
        #1;
        chk("idle_ack", wb_ack_o, 1'b0);
        step();
        chk("rd_rp_next", rp_inc_o, 1'b0);

        // Writes: outputs are the inverted line requests.
        do_write("wr00", 1'b0, 1'b0, 1'b1, 1'b1);
        do_write("wr11", 1'b1, 1'b1, 1'b0, 1'b0);
        do_write("wr01", 1'b0, 1'b1, 1'b1, 1'b0);

        // Read after write leaves enables alone.
        wb_stb_i   = 1'b1;
        wb_we_i    = 1'b0;
        wb_dat_8_i = 1'b1;
        wb_dat_9_i = 1'b0;
        step();
        chk("rd2_c_oe", c_oe_o, 1'b1);
        chk("rd2_d_oe", d_oe_o, 1'b0);
        chk("rd2_rp", rp_inc_o, 1'b0);

        // Back-to-back writes; a mid-cycle glitch on we must be ignored.
        wb_we_i    = 1'b1;
        wb_dat_8_i = 1'b1;
        wb_dat_9_i = 1'b1;
        step();
        chk("b2b_rp1", rp_inc_o, 1'b1);
        chk("b2b_c1", c_oe_o, 1'b0);
        wb_we_i = 1'b0;
        #2;
        wb_we_i    = 1'b1;
        wb_dat_8_i = 1'b0;
        step();
        chk("b2b_rp2", rp_inc_o, 1'b1);
        chk("b2b_c2", c_oe_o, 1'b1);
        chk("b2b_d2", d_oe_o, 1'b0);
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        step();
        chk("b2b_rp3", rp_inc_o, 1'b0);

        // Asynchronous reset between edges while a pop is pending.
        wb_stb_i   = 1'b1;
        wb_we_i    = 1'b1;
        wb_dat_8_i = 1'b0;
        wb_dat_9_i = 1'b0;
        step();
        chk("ar_pre_rp", rp_inc_o, 1'b1);
        chk("ar_pre_c", c_oe_o, 1'b1);
        #2;
        sys_reset_i = 1'b0;
        #1;
        chk("ar_c_oe", c_oe_o, 1'b0);
        chk("ar_d_oe", d_oe_o, 1'b0);
        chk("ar_rp", rp_inc_o, 1'b0);
        chk("ar_ack", wb_ack_o, 1'b1);
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        #1;
        chk("ar_ack_low", wb_ack_o, 1'b0);
        step();
        sys_reset_i = 1'b1;
        step();
        chk("end_rp", rp_inc_o, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
